baby_snapshot: RTL and testbench
================================

Name: baby_snapshot

Overview:
- Capture stage directly upstream of the Manchester Baby output serialiser. It freezes the core's five 32-bit observation words (RAM data, address, accumulator, CI, PI) into a stable frame, so readout never sees words change mid-frame.
- Counts serialiser beats to detect end of frame.
- Double-buffers one pending capture and flags overruns.
- Single clock domain; the serialiser's step strobe arrives as a synchronous pulse.

Parameters:
- WORD_W, 32, width of each observed word
- NUM_WORDS, 5, number of words per frame (frame = WORD_W*NUM_WORDS bits)
- COUNT_W, 8, width of beat counter and frame counter

Ports:
- clk_i  in  1  system clock, rising edge
- reset_ni  in  1  asynchronous active-low reset
- capture_i  in  1  request to snapshot live core values (1-cycle pulse or level; sampled every edge)
- serialise_i  in  1  frame mode for next capture: 1 = bit-serial (160 beats), 0 = byte (20 beats)
- advance_i  in  1  serialiser consumed one beat (synchronous strobe)
- clear_i  in  1  clears overrun_o
- value_a_i..value_e_i  in  WORD_W each  live core words
- value_a_o..value_e_o  out  WORD_W each  frozen frame words, order a (MSW) .. e
- beat_o  out  COUNT_W  index of current beat within frame
- frame_valid_o  out  1  frame held and not yet fully read
- busy_o  out  1  state != IDLE
- overrun_o  out  1  sticky: a pending capture was overwritten
- frame_count_o  out  COUNT_W  completed frames, wraps 255->0

Behaviour:
- Reset (async, reset_ni=0) forces these to 0: all value_*_o, beat_o, frame_valid_o, busy_o, overrun_o, frame_count_o, shadow regs and latched mode. State goes to IDLE.
- last_beat = latched mode ? WORD_W*NUM_WORDS-1 (159) : WORD_W*NUM_WORDS/8-1 (19). Mode is latched at the edge a frame is loaded into the outputs; serialise_i changes mid-frame have no effect.
- States: IDLE, HOLD, PENDING.
- IDLE + capture_i:
  - next edge loads value_*_i into value_*_o and latches serialise_i
  - beat_o=0, frame_valid_o=1, go to HOLD
  - latency 1 cycle
- IDLE + advance_i: ignored.
- HOLD + advance_i with beat_o<last_beat: beat_o+1.
- HOLD + advance_i with beat_o==last_beat (frame done):
  - frame_count_o+1, frame_valid_o=0, go to IDLE
  - value_*_o keep last values; beat_o=0
- HOLD + capture_i (no frame done): live values and serialise_i go to shadow; go to PENDING. Outputs are unchanged.
- HOLD + capture_i + frame done, same edge:
  - live values load directly to outputs, beat_o=0, frame_valid_o stays 1, stay HOLD
  - frame_count_o+1, no overrun
- PENDING + advance_i: beat counting as in HOLD.
- PENDING + frame done:
  - shadow is promoted to outputs with its latched mode; beat_o=0; frame_count_o+1
  - go to HOLD, frame_valid_o stays 1
- PENDING + capture_i (no frame done): shadow overwritten with newest values; overrun_o=1.
- PENDING + capture_i + frame done: shadow promoted to outputs, live values into shadow, stay PENDING, no overrun.
- clear_i: overrun_o=0 next edge. If clear_i coincides with a new overrun event, set wins.
- busy_o is registered, equal to (next state != IDLE).
- Reset mid-frame: immediate return to reset values, with no partial count retained.

Optional Feature:
- Macro SNAPSHOT_PARITY_EN. Defined: adds output parity_o (1 bit), the XOR of all WORD_W*NUM_WORDS bits of the frame being loaded into value_*_o. It is registered on the same edge as the load and reset to 0.
- Not defined: no parity_o port and no parity logic.

Test Plan:
- Reset, then capture_i with a=0xDEADBEEF, e=0x00000001, serialise_i=0 -> after 1 edge value_a_o=0xDEADBEEF, value_e_o=1, frame_valid_o=1, busy_o=1, beat_o=0.
- Byte frame: 20 advance_i pulses -> beat_o 0..19, then frame_valid_o=0, busy_o=0, frame_count_o=1. A 21st pulse in IDLE -> no change.
- Serial frame with serialise_i toggled to 0 mid-frame -> still 160 beats to completion.
- Capture (A) in HOLD, second capture (B) in PENDING, then capture (C) -> overrun_o=1. Finishing frame -> outputs show C, not B. clear_i -> overrun_o=0.
- capture_i on same edge as final advance in HOLD -> new values loaded, frame_valid_o stays 1, overrun_o=0, frame_count_o increments.
- Assert reset_ni=0 at beat 7 in PENDING -> all outputs 0 asynchronously; frame_count_o=0. With SNAPSHOT_PARITY_EN, frame of all 0xFFFFFFFF -> parity_o=0; a=1, rest 0 -> parity_o=1.

Source files
------------

// File: rtl/baby_snapshot_if.sv
// Observation-port bundle between the Baby core/serialiser side and the
// snapshot stage. The master drives live words and strobes; the slave (the
// snapshot stage) returns the frozen frame and its status.
interface baby_snapshot_if #(
    parameter int WORD_W  = 32,
    parameter int COUNT_W = 8
);
    logic                capture_i;
    logic                serialise_i;
    logic                advance_i;
    logic                clear_i;
    logic [WORD_W-1:0]   value_a_i;
    logic [WORD_W-1:0]   value_b_i;
    logic [WORD_W-1:0]   value_c_i;
    logic [WORD_W-1:0]   value_d_i;
    logic [WORD_W-1:0]   value_e_i;
    logic [WORD_W-1:0]   value_a_o;
    logic [WORD_W-1:0]   value_b_o;
    logic [WORD_W-1:0]   value_c_o;
    logic [WORD_W-1:0]   value_d_o;
    logic [WORD_W-1:0]   value_e_o;
    logic [COUNT_W-1:0]  beat_o;
    logic                frame_valid_o;
    logic                busy_o;
    logic                overrun_o;
    logic [COUNT_W-1:0]  frame_count_o;

    modport master (
        output capture_i, serialise_i, advance_i, clear_i,
        output value_a_i, value_b_i, value_c_i, value_d_i, value_e_i,
        input  value_a_o, value_b_o, value_c_o, value_d_o, value_e_o,
        input  beat_o, frame_valid_o, busy_o, overrun_o, frame_count_o
    );

    modport slave (
        input  capture_i, serialise_i, advance_i, clear_i,
        input  value_a_i, value_b_i, value_c_i, value_d_i, value_e_i,
        output value_a_o, value_b_o, value_c_o, value_d_o, value_e_o,
        output beat_o, frame_valid_o, busy_o, overrun_o, frame_count_o
    );
endinterface

// File: rtl/baby_snapshot.sv
// Snapshot/capture stage ahead of the Manchester Baby output serialiser.
// Freezes five observation words into a frame, counts serialiser beats to
// find end of frame, holds one pending capture and flags overruns.
// Optional feature macro: SNAPSHOT_PARITY_EN adds parity_o (XOR of the
// whole frame, registered with the load).
module baby_snapshot #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 5,
    parameter int COUNT_W   = 8
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    baby_snapshot_if.slave  bus
`ifdef SNAPSHOT_PARITY_EN
    ,
    output logic            parity_o
`endif
);
    localparam int FRAME_W = WORD_W * NUM_WORDS;
    localparam logic [COUNT_W-1:0] LAST_SERIAL = COUNT_W'(FRAME_W - 1);
    localparam logic [COUNT_W-1:0] LAST_BYTE   = COUNT_W'(FRAME_W / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic                 mode_q, mode_d;
    logic                 shadow_mode_q, shadow_mode_d;
    logic [COUNT_W-1:0]   beat_q, beat_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [COUNT_W-1:0]   frame_count_q, frame_count_d;
`ifdef SNAPSHOT_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic [FRAME_W-1:0]   live_frame;
    logic [FRAME_W-1:0]   load_frame;
    logic                 load_mode;
    logic                 load_en;
    logic                 overrun_set;
    logic                 frame_done;
    logic [COUNT_W-1:0]   last_beat;

    // Word a is the most significant word of the frame.
    assign live_frame = {bus.value_a_i, bus.value_b_i, bus.value_c_i,
                         bus.value_d_i, bus.value_e_i};
    assign last_beat  = mode_q ? LAST_SERIAL : LAST_BYTE;

    // Next-state: beat counting, frame completion, capture/shadow routing.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        shadow_d      = shadow_q;
        mode_d        = mode_q;
        shadow_mode_d = shadow_mode_q;
        beat_d        = beat_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
`ifdef SNAPSHOT_PARITY_EN
        parity_d      = parity_q;
`endif
        load_en       = 1'b0;
        load_frame    = live_frame;
        load_mode     = bus.serialise_i;
        overrun_set   = 1'b0;
        frame_done    = (state_q != ST_IDLE) && bus.advance_i && (beat_q == last_beat);

        case (state_q)
            ST_IDLE: begin
                // Stray advance strobes are ignored while nothing is held.
                if (bus.capture_i) begin
                    load_en = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (frame_done) begin
                    frame_count_d = frame_count_q + 1'b1;
                    if (bus.capture_i) begin
                        load_en = 1'b1;
                    end else begin
                        state_d       = ST_IDLE;
                        frame_valid_d = 1'b0;
                        beat_d        = '0;
                    end
                end else begin
                    if (bus.advance_i) beat_d = beat_q + 1'b1;
                    if (bus.capture_i) begin
                        shadow_d      = live_frame;
                        shadow_mode_d = bus.serialise_i;
                        state_d       = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_done) begin
                    frame_count_d = frame_count_q + 1'b1;
                    load_en       = 1'b1;
                    load_frame    = shadow_q;
                    load_mode     = shadow_mode_q;
                    if (bus.capture_i) begin
                        shadow_d      = live_frame;
                        shadow_mode_d = bus.serialise_i;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    if (bus.advance_i) beat_d = beat_q + 1'b1;
                    if (bus.capture_i) begin
                        // Newest capture wins; the older pending one is lost.
                        shadow_d      = live_frame;
                        shadow_mode_d = bus.serialise_i;
                        overrun_set   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_en) begin
            frame_d       = load_frame;
            mode_d        = load_mode;
            beat_d        = '0;
            frame_valid_d = 1'b1;
`ifdef SNAPSHOT_PARITY_EN
            parity_d      = ^load_frame;
`endif
        end

        // A new overrun on the same edge as clear must stay visible.
        if (bus.clear_i) overrun_d = 1'b0;
        if (overrun_set) overrun_d = 1'b1;

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ST_IDLE;
            frame_q       <= '0;
            shadow_q      <= '0;
            mode_q        <= 1'b0;
            shadow_mode_q <= 1'b0;
            beat_q        <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
`ifdef SNAPSHOT_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            shadow_q      <= shadow_d;
            mode_q        <= mode_d;
            shadow_mode_q <= shadow_mode_d;
            beat_q        <= beat_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
`ifdef SNAPSHOT_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign bus.value_a_o     = frame_q[4*WORD_W +: WORD_W];
    assign bus.value_b_o     = frame_q[3*WORD_W +: WORD_W];
    assign bus.value_c_o     = frame_q[2*WORD_W +: WORD_W];
    assign bus.value_d_o     = frame_q[1*WORD_W +: WORD_W];
    assign bus.value_e_o     = frame_q[0*WORD_W +: WORD_W];
    assign bus.beat_o        = beat_q;
    assign bus.frame_valid_o = frame_valid_q;
    assign bus.busy_o        = busy_q;
    assign bus.overrun_o     = overrun_q;
    assign bus.frame_count_o = frame_count_q;
`ifdef SNAPSHOT_PARITY_EN
    assign parity_o          = parity_q;
`endif
endmodule

// File: tb/tb_baby_snapshot.sv
// Testbench for baby_snapshot: directed scenarios plus a randomized run,
// all compared against a frame/queue-level reference model.
module tb_baby_snapshot;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    baby_snapshot_if #(.WORD_W(32), .COUNT_W(8)) bus ();

`ifdef SNAPSHOT_PARITY_EN
    logic parity;
    baby_snapshot #(.WORD_W(32), .NUM_WORDS(5), .COUNT_W(8)) dut (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus), .parity_o(parity));
`else
    baby_snapshot #(.WORD_W(32), .NUM_WORDS(5), .COUNT_W(8)) dut (
        .clk_i(clk), .reset_ni(reset_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [159:0] f;
        logic         mode;
    } frm_t;

    logic [159:0] m_cur;
    bit           m_mode;
    bit           m_valid;
    frm_t         m_pend[$];
    int           m_beat;
    int           m_fc;
    bit           m_ov;
    bit           m_par;

    function automatic void model_reset();
        m_cur = '0; m_mode = 0; m_valid = 0; m_pend.delete();
        m_beat = 0; m_fc = 0; m_ov = 0; m_par = 0;
    endfunction

    function automatic void model_load(logic [159:0] f, bit mode);
        m_cur = f; m_mode = mode; m_beat = 0; m_valid = 1; m_par = ^f;
    endfunction

    // One clock edge: frame length is 160 beats (serial) or 20 (byte).
    function automatic void model_step(bit cap, bit ser, bit adv, bit clr, logic [159:0] live);
        bit   ov_set;
        bit   done;
        frm_t tmp;
        ov_set = 0;
        tmp.f = live; tmp.mode = ser;
        if (!m_valid) begin
            if (cap) model_load(live, ser);
        end else begin
            done = adv && (m_beat == (m_mode ? 160 : 20) - 1);
            if (done) begin
                m_fc = (m_fc + 1) % 256;
                m_beat = 0;
                if (m_pend.size() > 0) begin
                    model_load(m_pend[0].f, m_pend[0].mode);
                    m_pend.delete();
                    if (cap) m_pend.push_back(tmp);
                end else if (cap) begin
                    model_load(live, ser);
                end else begin
                    m_valid = 0;
                end
            end else begin
                if (adv) m_beat++;
                if (cap) begin
                    if (m_pend.size() > 0) begin
                        ov_set = 1;
                        m_pend.delete();
                    end
                    m_pend.push_back(tmp);
                end
            end
        end
        if (clr) m_ov = 0;
        if (ov_set) m_ov = 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [159:0] live_frame();
        return {bus.value_a_i, bus.value_b_i, bus.value_c_i, bus.value_d_i, bus.value_e_i};
    endfunction

    function automatic logic [159:0] out_frame();
        return {bus.value_a_o, bus.value_b_o, bus.value_c_o, bus.value_d_o, bus.value_e_o};
    endfunction

    function automatic logic [159:0] rand_frame();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_words(input logic [159:0] f);
        bus.value_a_i = f[159:128];
        bus.value_b_i = f[127:96];
        bus.value_c_i = f[95:64];
        bus.value_d_i = f[63:32];
        bus.value_e_i = f[31:0];
    endtask

    task automatic set_in(input bit cap, input bit ser, input bit adv, input bit clr);
        bus.capture_i = cap; bus.serialise_i = ser; bus.advance_i = adv; bus.clear_i = clr;
    endtask

    // Advance one edge, step the model with the inputs the DUT saw, settle.
    task automatic tick();
        @(posedge clk);
        model_step(bus.capture_i, bus.serialise_i, bus.advance_i, bus.clear_i, live_frame());
        #1;
    endtask

    task automatic advance_n(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 1, 0);
            tick();
        end
        set_in(0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 0);
        set_words('0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_frame(), bus.beat_o, bus.frame_valid_o, bus.busy_o, bus.overrun_o, bus.frame_count_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got frame=%h beat=%0d fv=%b busy=%b ov=%b fc=%0d, expected all zero",
                     out_frame(), bus.beat_o, bus.frame_valid_o, bus.busy_o, bus.overrun_o, bus.frame_count_o);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.frame_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b fv=%b, expected 0 0", bus.busy_o, bus.frame_valid_o);
        end
        $display("test_reset: done");
    endtask

    task automatic test_first_capture();
        logic [159:0] f;
        f = rand_frame();
        f[159:128] = 32'hDEADBEEF;
        f[31:0]    = 32'h00000001;
        set_words(f);
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (bus.value_a_o !== 32'hDEADBEEF || bus.value_e_o !== 32'h1) begin
            errors++;
            $display("FAIL first_capture_words: a=%h e=%h, expected deadbeef 00000001", bus.value_a_o, bus.value_e_o);
        end
        checks++;
        if ({bus.frame_valid_o, bus.busy_o, bus.beat_o} !== {1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL first_capture_status: fv=%b busy=%b beat=%0d, expected 1 1 0",
                     bus.frame_valid_o, bus.busy_o, bus.beat_o);
        end
        checks++;
        if (out_frame() !== f) begin
            errors++;
            $display("FAIL first_capture_frame: got %h expected %h", out_frame(), f);
        end
        $display("test_first_capture: frame=%h", out_frame());
    endtask

    task automatic test_byte_frame();
        int beat_err;
        beat_err = 0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.beat_o !== 8'(i)) begin
                errors++;
                $display("FAIL byte_beat: got %0d expected %0d", bus.beat_o, i);
            end
            set_in(0, 0, 1, 0);
            tick();
        end
        set_in(0, 0, 0, 0);
        checks++;
        if ({bus.frame_valid_o, bus.busy_o, bus.frame_count_o} !== {1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL byte_frame_end: fv=%b busy=%b fc=%0d, expected 0 0 1",
                     bus.frame_valid_o, bus.busy_o, bus.frame_count_o);
        end
        advance_n(1);
        checks++;
        if ({bus.frame_valid_o, bus.beat_o, bus.frame_count_o, bus.value_a_o} !== {1'b0, 8'd0, 8'd1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL idle_advance_ignored: fv=%b beat=%0d fc=%0d a=%h, expected 0 0 1 deadbeef",
                     bus.frame_valid_o, bus.beat_o, bus.frame_count_o, bus.value_a_o);
        end
        $display("test_byte_frame: frame_count=%0d", bus.frame_count_o);
    endtask

    task automatic test_serial_mode_change();
        set_words(rand_frame());
        set_in(1, 1, 0, 0);
        tick();
        for (int i = 0; i < 159; i++) begin
            set_in(0, (i < 10), 1, 0);
            tick();
        end
        set_in(0, 0, 0, 0);
        checks++;
        if ({bus.frame_valid_o, bus.beat_o} !== {1'b1, 8'd159}) begin
            errors++;
            $display("FAIL serial_beat159: fv=%b beat=%0d, expected 1 159", bus.frame_valid_o, bus.beat_o);
        end
        advance_n(1);
        checks++;
        if ({bus.frame_valid_o, bus.busy_o, bus.frame_count_o} !== {1'b0, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL serial_frame_end: fv=%b busy=%b fc=%0d, expected 0 0 2",
                     bus.frame_valid_o, bus.busy_o, bus.frame_count_o);
        end
        $display("test_serial_mode_change: frame_count=%0d", bus.frame_count_o);
    endtask

    task automatic test_overrun();
        logic [159:0] fc_frame;
        set_words(rand_frame()); set_in(1, 0, 0, 0); tick();
        set_words(rand_frame()); tick();
        fc_frame = rand_frame();
        set_words(fc_frame); tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (bus.overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", bus.overrun_o);
        end
        advance_n(20);
        checks++;
        if (out_frame() !== fc_frame || bus.frame_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_promote_newest: frame=%h fv=%b, expected %h 1", out_frame(), bus.frame_valid_o, fc_frame);
        end
        set_in(0, 0, 0, 1); tick(); set_in(0, 0, 0, 0);
        checks++;
        if (bus.overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", bus.overrun_o);
        end
        advance_n(20);
        checks++;
        if ({bus.busy_o, bus.frame_count_o} !== {1'b0, 8'd4}) begin
            errors++;
            $display("FAIL overrun_drain: busy=%b fc=%0d, expected 0 4", bus.busy_o, bus.frame_count_o);
        end
        $display("test_overrun: frame=%h", out_frame());
    endtask

    task automatic test_back_to_back();
        logic [159:0] e_frame;
        set_words(rand_frame()); set_in(1, 0, 0, 0); tick(); set_in(0, 0, 0, 0);
        advance_n(19);
        e_frame = rand_frame();
        set_words(e_frame);
        set_in(1, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (out_frame() !== e_frame) begin
            errors++;
            $display("FAIL back_to_back_frame: got %h expected %h", out_frame(), e_frame);
        end
        checks++;
        if ({bus.frame_valid_o, bus.overrun_o, bus.beat_o, bus.frame_count_o, bus.busy_o} !== {1'b1, 1'b0, 8'd0, 8'd5, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back_status: fv=%b ov=%b beat=%0d fc=%0d busy=%b, expected 1 0 0 5 1",
                     bus.frame_valid_o, bus.overrun_o, bus.beat_o, bus.frame_count_o, bus.busy_o);
        end
        advance_n(20);
        $display("test_back_to_back: frame_count=%0d", bus.frame_count_o);
    endtask

    task automatic test_reset_midframe();
        set_words(rand_frame()); set_in(1, 0, 0, 0); tick();
        set_words(rand_frame()); tick();
        set_in(0, 0, 0, 0);
        advance_n(7);
        checks++;
        if ({bus.beat_o, bus.busy_o} !== {8'd7, 1'b1}) begin
            errors++;
            $display("FAIL pending_beat7: beat=%0d busy=%b, expected 7 1", bus.beat_o, bus.busy_o);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_frame(), bus.beat_o, bus.frame_valid_o, bus.busy_o, bus.overrun_o, bus.frame_count_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_midframe: frame=%h beat=%0d fv=%b busy=%b ov=%b fc=%0d, expected all zero",
                     out_frame(), bus.beat_o, bus.frame_valid_o, bus.busy_o, bus.overrun_o, bus.frame_count_o);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        $display("test_reset_midframe: frame_count=%0d", bus.frame_count_o);
    endtask

`ifdef SNAPSHOT_PARITY_EN
    task automatic test_parity();
        logic [159:0] f;
        f = '1;
        set_words(f); set_in(1, 0, 0, 0); tick(); set_in(0, 0, 0, 0);
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_all_ones: got %b expected 0", parity);
        end
        advance_n(20);
        f = '0;
        f[128] = 1'b1;
        set_words(f); set_in(1, 0, 0, 0); tick(); set_in(0, 0, 0, 0);
        checks++;
        if (parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_single_bit: got %b expected 1", parity);
        end
        advance_n(20);
        $display("test_parity: done");
    endtask
`endif

    task automatic test_random();
        bit ok;
        for (int n = 0; n < 4000; n++) begin
            set_words(rand_frame());
            set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            tick();
            ok = 1;
            checks++;
            if (out_frame() !== m_cur) begin
                ok = 0; errors++;
                $display("FAIL rand_frame[%0d]: got %h expected %h", n, out_frame(), m_cur);
            end
            checks++;
            if (bus.beat_o !== 8'(m_beat) || bus.frame_count_o !== 8'(m_fc)) begin
                ok = 0; errors++;
                $display("FAIL rand_counts[%0d]: beat=%0d fc=%0d expected %0d %0d",
                         n, bus.beat_o, bus.frame_count_o, m_beat, m_fc);
            end
            checks++;
            if ({bus.frame_valid_o, bus.busy_o, bus.overrun_o} !== {m_valid, m_valid, m_ov}) begin
                ok = 0; errors++;
                $display("FAIL rand_flags[%0d]: fv=%b busy=%b ov=%b expected %b %b %b",
                         n, bus.frame_valid_o, bus.busy_o, bus.overrun_o, m_valid, m_valid, m_ov);
            end
`ifdef SNAPSHOT_PARITY_EN
            checks++;
            if (parity !== m_par) begin
                ok = 0; errors++;
                $display("FAIL rand_parity[%0d]: got %b expected %b", n, parity, m_par);
            end
`endif
            if (!ok) break;
        end
        set_in(0, 0, 0, 0);
        $display("test_random: frames=%0d", m_fc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_first_capture();
        test_byte_frame();
        test_serial_mode_change();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
`ifdef SNAPSHOT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
